// File: rtl/i2s_tx_pkg.sv
// Shared audio package: default slot width, bit-clock divider and frame length.
// Used by i2s_tx and its bit-clock generator.
package i2s_tx_pkg;

  localparam int unsigned SLOT_W_DEF    = 16;
  localparam int unsigned DIV_DEF       = 4;
  localparam int unsigned FRAME_LEN_DEF = 2 * SLOT_W_DEF;

  // Number of bclk periods in one stereo frame for a given slot width.
  function automatic int unsigned frame_len(input int unsigned slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by 2*DIV to produce a registered bclk and
// a single-cycle strobe marking the edge on which bclk is registered 1->0.
// With en low the divider is parked at 0 and bclk is held low.
module i2s_bclk_gen
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  // Divider count and bclk toggle on wrap.
  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    wrap   = (div_q == DIV_LAST);
    if (!en) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  // Divider and bclk registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign fall = en && wrap && bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: single-entry sample holding register, frame bit counter and
// MSB-first shift register producing bclk / lrck / sdata with the standard
// one-bit data delay after each lrck edge. Missing samples at a frame start
// are replaced by zeros.
// Optional build macro: I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter output (underrun_cnt).
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned SLOT_W = SLOT_W_DEF,
  parameter int unsigned DIV    = DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*SLOT_W-1:0]   x,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic                  en,
  output logic                  bclk,
  output logic                  lrck,
  output logic                  sdata
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int unsigned FRAME_LEN = frame_len(SLOT_W);
  localparam int unsigned B_W       = $clog2(FRAME_LEN);
  localparam logic [B_W-1:0] B_LAST = B_W'(FRAME_LEN - 1);
  localparam logic [B_W-1:0] B_SLOT = B_W'(SLOT_W);

  logic [FRAME_LEN-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d;
  logic [B_W-1:0]       b_q, b_d;
  logic [B_W-1:0]       b_next;
  logic                 lrck_q, lrck_d;
  logic                 sdata_q, sdata_d;
  logic                 fall;
  logic                 accept;
  logic                 load;
  logic                 underrun;

  i2s_bclk_gen #(
    .DIV (DIV)
  ) u_bclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bclk (bclk),
    .fall (fall)
  );

  // Holding register, frame bit counter, shift register and serial outputs.
  // A sample accepted on a load edge is not seen by that load (hold_full_q
  // is still 0), so the frame is zero-filled and the sample waits a frame.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sr_d        = sr_q;
    b_d         = b_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;

    accept   = x_valid && !hold_full_q;
    b_next   = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
    load     = fall && (b_next == '0);
    underrun = load && !hold_full_q;

    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = x;
      hold_full_d = 1'b1;
    end

    if (!en) begin
      b_d     = B_LAST;
      lrck_d  = 1'b0;
      sdata_d = 1'b0;
    end else if (fall) begin
      b_d     = b_next;
      lrck_d  = (b_next >= B_SLOT);
      sdata_d = sr_q[FRAME_LEN-1];
      if (b_next == '0) begin
        sr_d = hold_full_q ? hold_q : '0;
      end else begin
        sr_d = {sr_q[FRAME_LEN-2:0], 1'b0};
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      b_q         <= B_LAST;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sr_q        <= sr_d;
      b_q         <= b_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
    end
  end

  assign x_ready = !hold_full_q;
  assign lrck    = lrck_q;
  assign sdata   = sdata_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of zero-filled frame loads.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`else
  logic unused_underrun;
  assign unused_underrun = underrun;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx (SLOT_W=16, DIV=2). Expected serial bits are queued
// by the stimulus; a monitor pops and compares one entry per bclk fall.
module tb_i2s_tx;

  localparam int SLOT_W = 16;
  localparam int DIV    = 2;
  localparam int FL     = 2 * SLOT_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x = '0;
  logic        x_valid = 1'b0;
  logic        en = 1'b0;
  logic        x_ready, bclk, lrck, sdata;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  i2s_tx #(.SLOT_W(SLOT_W), .DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .x_valid      (x_valid),
    .x_ready      (x_ready),
    .en           (en),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_q[$];
  int         tb_b     = FL - 1;
  int         fall_cnt = 0;
  int         cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_cnt(input string name, input int exp);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk(name, 32'(underrun_cnt), 32'(exp));
`endif
  endtask

  // Expected {lrck, sdata} for b = 0 .. nbits-1 of a frame carrying s;
  // b=0 carries the previous frame's last bit.
  task automatic push_frame(input logic prev, input logic [31:0] s, input int nbits);
    logic [1:0] v;
    for (int b = 0; b < nbits; b++) begin
      v[1] = (b >= SLOT_W);
      v[0] = (b == 0) ? prev : s[FL-b];
      exp_q.push_back(v);
    end
  endtask

  task automatic wait_b(input int target, input string tag);
    int  seen;
    bit  ok;
    seen = fall_cnt;
    ok   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (fall_cnt != seen) begin
        seen = fall_cnt;
        if (tb_b == target) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout_%s: b stuck at %0d, wanted %0d", tag, tb_b, target);
    end
  endtask

  // Monitor: every bclk 1->0 while enabled and out of reset is one bit.
  initial begin : monitor
    logic       prev_bclk;
    logic       en_s, rst_s;
    int         last_fall;
    int         idx;
    logic [1:0] e;
    prev_bclk = 1'b0;
    last_fall = -1;
    idx       = 0;
    forever begin
      @(posedge clk);
      en_s  = en;
      rst_s = rst;
      cyc++;
      #1;
      if (rst_s || rst || !en_s) begin
        prev_bclk = 1'b0;
        tb_b      = FL - 1;
        last_fall = -1;
      end else begin
        if (prev_bclk && !bclk) begin
          tb_b = (tb_b == FL - 1) ? 0 : tb_b + 1;
          fall_cnt++;
          if (last_fall >= 0) chk("bclk_period", 32'(cyc - last_fall), 32'(2 * DIV));
          last_fall = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_bit: b=%0d lrck=%0b sdata=%0b, expected no bit", tb_b, lrck, sdata);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("bit%0d_b%0d", idx, tb_b), {30'd0, lrck, sdata}, {30'd0, e});
          end
          idx++;
        end
        prev_bclk = bclk;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int k;
    // Reset state
    repeat (3) @(posedge clk); #2;
    chk("rst_bclk", 32'(bclk), 0);
    chk("rst_lrck", 32'(lrck), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_xready", 32'(x_ready), 1);
    chk_cnt("rst_cnt", 0);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_xready", 32'(x_ready), 1);

    // Frame 1: A5A5_3C3C; frame 2: nothing offered (zeros, one underrun)
    x = 32'hA5A5_3C3C; x_valid = 1'b1;
    @(posedge clk); #2;
    x_valid = 1'b0;
    chk("accept_xready", 32'(x_ready), 0);
    push_frame(1'b0, 32'hA5A5_3C3C, FL);
    push_frame(1'b0, 32'h0, FL);
    en = 1'b1;
    wait_b(0, "f1_load");
    chk("f1_load_xready", 32'(x_ready), 1);
    wait_b(0, "f2_load");
    wait_b(2, "f2_b2");
    chk_cnt("f2_underrun_cnt", 1);

    // Back-to-back samples: second waits until the frame-3 load
    push_frame(1'b0, 32'h1111_2222, FL);
    push_frame(1'b0, 32'h3333_4444, FL);
    x = 32'h1111_2222; x_valid = 1'b1;
    @(posedge clk); #2;
    chk("b2b_first_held", 32'(x_ready), 0);
    x = 32'h3333_4444;
    k = 0;
    while (!x_ready && k < 300) begin
      @(posedge clk); #2;
      k++;
    end
    chk("b2b_ready_rise", 32'(x_ready), 1);
    chk("b2b_ready_rise_b", 32'(tb_b), 0);
    @(posedge clk); #2;
    x_valid = 1'b0;
    chk("b2b_second_held", 32'(x_ready), 0);

    // Sample offered exactly on the frame-5 load edge
    wait_b(0, "f4_load");
    wait_b(FL - 1, "f4_end");
    push_frame(1'b0, 32'h0, FL);
    push_frame(1'b0, 32'h5A5A_C3C3, 11);
    repeat (3) @(posedge clk); #2;
    x = 32'h5A5A_C3C3; x_valid = 1'b1;
    @(posedge clk); #2;
    x_valid = 1'b0;
    chk("loadcyc_align_b", 32'(tb_b), 0);
    chk("loadcyc_held", 32'(x_ready), 0);
    wait_b(2, "f5_b2");
    chk_cnt("f5_underrun_cnt", 2);
    chk("f5_still_held", 32'(x_ready), 0);

    // en dropped at b=10 of frame 6, restarted about 20 clk later
    wait_b(0, "f6_load");
    wait_b(10, "f6_b10");
    en = 1'b0;
    @(posedge clk); #2;
    chk("endrop_bclk", 32'(bclk), 0);
    chk("endrop_lrck", 32'(lrck), 0);
    chk("endrop_sdata", 32'(sdata), 0);
    x = 32'h0F0F_F0F0; x_valid = 1'b1;
    @(posedge clk); #2;
    x_valid = 1'b0;
    chk("endis_accept", 32'(x_ready), 0);
    push_frame(1'b0, 32'h0F0F_F0F0, 21);
    repeat (18) @(posedge clk); #2;
    en = 1'b1;
    wait_b(2, "f7_b2");
    chk_cnt("f7_underrun_cnt", 2);
    x = 32'h7777_8888; x_valid = 1'b1;
    @(posedge clk); #2;
    x_valid = 1'b0;
    chk("f7_accept", 32'(x_ready), 0);

    // Reset mid-frame while bclk is high
    wait_b(20, "f7_b20");
    @(posedge clk); @(posedge clk); #3;
    chk("prerst_bclk", 32'(bclk), 1);
    chk("prerst_lrck", 32'(lrck), 1);
    chk("prerst_sdata", 32'(sdata), 1);
    rst = 1'b1;
    #1;
    chk("midrst_bclk", 32'(bclk), 0);
    chk("midrst_lrck", 32'(lrck), 0);
    chk("midrst_sdata", 32'(sdata), 0);
    chk("midrst_xready", 32'(x_ready), 1);
    chk_cnt("midrst_cnt", 0);
    en = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    x = 32'h8001_0001; x_valid = 1'b1;
    @(posedge clk); #2;
    x_valid = 1'b0;
    chk("postrst_accept", 32'(x_ready), 0);
    push_frame(1'b0, 32'h8001_0001, FL);
    push_frame(1'b1, 32'h0, 2);
    en = 1'b1;
    wait_b(0, "f9_load");
    wait_b(0, "f10_load");
    wait_b(1, "f10_b1");
    en = 1'b0;
    chk_cnt("f10_underrun_cnt", 1);
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter SLOT_W, default 16: bits per channel slot; frame is 2*SLOT_W bclk periods.
REQ-002 SHALL have parameter DIV, default 4: clk cycles per bclk half-period, legal range 2..255.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port x, input, 2*SLOT_W: stereo sample; left in the upper half, right in the lower half, two's complement.
REQ-006 SHALL have port x_valid, input, 1: x is valid this cycle.
REQ-007 SHALL have port x_ready, output, 1: block accepts x this cycle.
REQ-008 SHALL have port en, input, 1: enables serialisation.
REQ-009 SHALL have port bclk, output, 1: serial bit clock, registered.
REQ-010 SHALL have port lrck, output, 1: word select; 0 = left, 1 = right; registered.
REQ-011 SHALL have port sdata, output, 1: serial data, MSB first, registered.

Function
REQ-012 SHALL accept a sample into a single-entry holding register when x_valid && x_ready; x_ready = !hold_full.
REQ-013 SHALL run divider counter 0..DIV-1 while en=1; bclk toggles on the cycle the counter wraps; bclk period = 2*DIV clk.
REQ-014 SHALL define a "fall event" as the cycle in which bclk is registered 1->0; bit counter b (0..2*SLOT_W-1, wrapping) advances only on fall events.
REQ-015 SHALL, on each fall event, register lrck = (new b >= SLOT_W) and sdata = sr[MSB], where sr is a 2*SLOT_W shift register.
REQ-016 SHALL, on a fall event where new b = 0, load sr from the holding register and clear hold_full; otherwise shift sr left by one.
REQ-017 SHALL therefore present the left MSB at b=1, right MSB at b=SLOT_W+1, and right LSB at b=0 of the next frame (standard one-bit I2S delay).
REQ-018 SHALL, when hold_full=0 at a load, load all-zeros into sr (underrun); no stale sample is repeated.
REQ-019 SHALL treat a sample accepted in the same cycle as a load as not present for that load: the load is an underrun and the sample is kept for the next frame.
REQ-020 SHALL, while en=0, hold the divider at 0, b at 2*SLOT_W-1, and bclk, lrck, sdata at 0; sr keeps its value and the holding register keeps accepting samples.
REQ-021 SHALL make the first fall event after en rises a frame-start load (b wraps to 0).
REQ-022 SHALL make en deassertion mid-frame take effect on the next clk edge, aborting the frame with no completion.

Reset
REQ-023 SHALL, on rst, asynchronously clear bclk, lrck, sdata, divider, sr, and hold_full, and set b to 2*SLOT_W-1; x_ready reads 1 after rst.
REQ-024 SHALL discard any held sample and any partial frame on rst mid-operation.

Configuration
REQ-025 SHALL, with macro I2S_TX_UNDERRUN_CNT_EN defined, add output underrun_cnt[15:0], which increments by 1 per underrun load, saturates at 0xFFFF, and is cleared by rst.
REQ-026 SHALL, without I2S_TX_UNDERRUN_CNT_EN, omit the port and counter; zero-insertion on underrun still applies.

Structure
REQ-027 SHALL place SLOT_W and DIV defaults and the frame-length constant (2*SLOT_W) in the shared audio package used by the effect blocks.
REQ-028 SHALL implement the divider and fall-event strobe as sub-module i2s_bclk_gen (inputs clk, rst, en; outputs bclk, fall).

Verification (DIV=2, SLOT_W=16)
REQ-029 SHALL check rst asserted mid-frame -> bclk=lrck=sdata=0 immediately, x_ready=1, next frame starts at b=0 after rst release and en=1.
REQ-030 SHALL check x=0xA5A5_3C3C with en=1 -> lrck low for b=0..15, bits 1010_0101_1010_0101 on b=1..16, 0011_1100_0011_1100 on b=17..31 plus next b=0; bclk period 4 clk.
REQ-031 SHALL check no sample offered for one frame -> sdata=0 for the whole frame and underrun_cnt=1 (macro on).
REQ-032 SHALL check two back-to-back valid samples 0x1111_2222 and 0x3333_4444 -> second held with x_ready=0 until the next load, then both serialise in order.
REQ-033 SHALL check sample accepted on the exact load cycle -> that frame is zero, the sample appears in the following frame, and underrun_cnt increments.
REQ-034 SHALL check en dropped at b=10 and raised 20 clk later -> outputs 0 next cycle, and a fresh frame restarts at b=0 with the held or zero sample.
